icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache between Fetch0 and the instruction queue.
- Provides one-cycle SRAM lookup and a single outstanding line miss to the memory subsystem.
- Victim choice is invalid-first, then per-set round-robin.
- Adds flush-all (fence.i) and squash-safe miss draining: a refill already requested is always written into the cache, never dropped.

Parameters:
WAY_NUM, 4, associativity (power of two, >=2)
SET_NUM, 64, sets (power of two)
LINE_BYTES, 64, line size in bytes; LINE_W = 8*LINE_BYTES
ADDR_WIDTH, 64, PC width; OFF_W=log2(LINE_BYTES), IDX_W=log2(SET_NUM), TAG_W=ADDR_WIDTH-OFF_W-IDX_W

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
f0_valid_i  in  1  fetch request valid
f0_pc_i  in  ADDR_WIDTH  fetch PC
stall_f0_o  out  1  request not accepted this cycle
icache_valid_o  out  1  line valid to instQueue
icache_pc_o  out  ADDR_WIDTH  PC of the presented line
icache_data_o  out  LINE_W  line data
stall_icache_i  in  1  instQueue back-pressure; holds the output
miss_valid_o  out  1  miss request
miss_ready_i  in  1  miss request accepted
miss_addr_o  out  ADDR_WIDTH  line-aligned miss address (offset bits zero)
refill_valid_i  in  1  refill line valid
refill_ready_o  out  1  high in MISS_WAIT/DRAIN only
refill_data_i  in  LINE_W  refill line
squash_pipe_i  in  1  backend squash
flush_i  in  1  invalidate-all request (pulse)
flush_ack_o  out  1  one-cycle pulse when invalidation done

Behaviour:
- State machine, reset to IDLE:
  - IDLE: no lookup in flight.
  - LOOKUP: SRAM Q valid; hit/miss resolved.
  - MISS_REQ: miss_valid_o high.
  - MISS_WAIT: waiting for refill.
  - RESP: refill line presented.
  - DRAIN: squashed miss awaiting refill.
- Reset clears all valid bits, round-robin pointers and flush_pending; all outputs are 0.
- Accept: acc = f0_valid_i & !squash_pipe_i & !flush_pending & (IDLE | (LOOKUP & hit & !stall_icache_i) | (RESP & !stall_icache_i)).
  - stall_f0_o = f0_valid_i & !acc.
  - On acc, read all ways' tag/data SRAMs at idx and register the PC; next state is LOOKUP.
- Lookup latency is 1 cycle. hit_way[w] = valid[idx][w] & tag_q[w]==tag_r.
  - More than one hit way is illegal; the bench asserts on it.
  - Hit: icache_valid_o=1 with the hit way's data.
  - While stall_icache_i is high, state, PC and SRAM Q are held (SRAMs are not re-enabled).
  - Hit with !stall and no acc: next state IDLE.
- Miss in LOOKUP: go to MISS_REQ; icache_valid_o=0.
- MISS_REQ: miss_valid_o=1 and miss_addr_o stay stable until miss_ready_i, then MISS_WAIT.
- MISS_WAIT, on refill_valid_i:
  - Write tag and data into victim way, set valid, update the RR pointer.
  - Register the line and go to RESP.
- RESP: icache_valid_o=1 with the registered refill line; hold under stall.
- Victim: the lowest-index invalid way in the set; if none, rr_ptr[set].
  - rr_ptr[set] increments mod WAY_NUM only when rr_ptr was used.
- Squash (highest priority):
  - From IDLE, LOOKUP, RESP or MISS_REQ, next state is IDLE with the output dropped. MISS_REQ is dropped even if miss_ready_i is high in the same cycle.
  - From MISS_WAIT, go to DRAIN. DRAIN writes the refill line into the cache with no output, then goes to IDLE.
  - Squash in the same cycle as refill_valid_i in MISS_WAIT: the line is written and the next state is IDLE.
- Flush:
  - flush_i sets flush_pending, which blocks accept.
  - When state==IDLE and flush_pending: clear all valid bits and RR pointers, clear flush_pending, assert flush_ack_o the next cycle.
  - A flush during a miss waits for the refill write, so the flushed-after line is invalidated.
  - flush_i while flush_pending is already set is absorbed.
- The SRAM write port is used only in MISS_WAIT/DRAIN, where no read is accepted, so there is no read/write conflict.

Decomposition:
- Package icache_pkg: state enum, clog2-derived widths (OFF_W, IDX_W, TAG_W), line-address helper.
- Sub-module icache_replace: per-set valid bits and rr_ptr; victim select and update; flush clear.
- Tag and data arrays use existing sram_model instances, one tag and one data array per way, via generate.

Test Plan:
- Cold miss PC=0x1040 → miss_addr_o=0x1040 and refill_ready_o high; refill D → one cycle later icache_valid_o=1, data=D, pc=0x1040. Refetch 0x1040 → hit one cycle after accept, no miss_valid_o.
- WAY_NUM=4, five distinct tags mapping to set 1: ways 0-3 filled; 5th tag evicts way 0 and the next conflicting miss evicts way 1. Refetching the first tag misses.
- Hit with stall_icache_i high 3 cycles → icache_valid_o, pc and data stable 4 cycles; stall_f0_o=1; no SRAM read enable.
- Squash in MISS_WAIT, then refill → line written, no icache_valid_o; refetch of the same PC hits.
- Squash in MISS_REQ with miss_ready_i=1 the same cycle → no refill expected; next state IDLE.
- flush_i during MISS_WAIT → refill written, then flush_ack_o pulses; next fetch of any PC misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  localparam int DEF_WAY_NUM    = 4;
  localparam int DEF_SET_NUM    = 64;
  localparam int DEF_LINE_BYTES = 64;
  localparam int DEF_ADDR_WIDTH = 64;

  function automatic int calc_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_idx_w(input int set_num);
    return $clog2(set_num);
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int line_bytes, input int set_num);
    return addr_width - $clog2(line_bytes) - $clog2(set_num);
  endfunction

  // Clears the byte-offset bits so the address names a whole line.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_replace.sv
// Per-set valid bits and round-robin pointers; picks the refill victim way.
module icache_replace #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_clr,
  input  logic [$clog2(SET_NUM)-1:0] idx,
  input  logic                       upd,
  output logic [WAY_NUM-1:0]         valid_row,
  output logic [$clog2(WAY_NUM)-1:0] victim
);

  localparam int WAY_W = $clog2(WAY_NUM);

  logic [WAY_NUM-1:0] valid [SET_NUM];
  logic [WAY_W-1:0]   rr    [SET_NUM];
  logic               any_invalid;
  logic [WAY_W-1:0]   first_inv;

  assign valid_row = valid[idx];

  // Scan downward so the lowest-index invalid way wins.
  always_comb begin
    any_invalid = 1'b0;
    first_inv   = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid[idx][w]) begin
        any_invalid = 1'b1;
        first_inv   = WAY_W'(w);
      end
    end
  end

  assign victim = any_invalid ? first_inv : rr[idx];

  always_ff @(posedge clk) begin
    if (rst || flush_clr) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else if (upd) begin
      valid[idx][victim] <= 1'b1;
      if (!any_invalid) rr[idx] <= rr[idx] + WAY_W'(1);
    end
  end

endmodule

// File: rtl/sram_model.sv
// Single-port synchronous SRAM: registered read, write-only cycles leave Q untouched.
module sram_model #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with one outstanding miss,
// squash-safe refill draining and flush-all.
module icache_nway
  import icache_pkg::*;
#(
  parameter int  WAY_NUM    = DEF_WAY_NUM,
  parameter int  SET_NUM    = DEF_SET_NUM,
  parameter int  LINE_BYTES = DEF_LINE_BYTES,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int LINE_W     = 8 * LINE_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f0_valid_i,
  input  logic [ADDR_WIDTH-1:0] f0_pc_i,
  output logic                  stall_f0_o,
  output logic                  icache_valid_o,
  output logic [ADDR_WIDTH-1:0] icache_pc_o,
  output logic [LINE_W-1:0]     icache_data_o,
  input  logic                  stall_icache_i,
  output logic                  miss_valid_o,
  input  logic                  miss_ready_i,
  output logic [ADDR_WIDTH-1:0] miss_addr_o,
  input  logic                  refill_valid_i,
  output logic                  refill_ready_o,
  input  logic [LINE_W-1:0]     refill_data_i,
  input  logic                  squash_pipe_i,
  input  logic                  flush_i,
  output logic                  flush_ack_o
);

  localparam int OFF_W = calc_off_w(LINE_BYTES);
  localparam int IDX_W = calc_idx_w(SET_NUM);
  localparam int TAG_W = calc_tag_w(ADDR_WIDTH, LINE_BYTES, SET_NUM);
  localparam int WAY_W = $clog2(WAY_NUM);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [LINE_W-1:0]     line_r;
  logic                  flush_pending, flush_ack_r, flush_clr;
  logic                  acc, refill_wr, hit;
  logic [IDX_W-1:0]      idx_r, sram_addr;
  logic [TAG_W-1:0]      tag_r;
  logic [WAY_NUM-1:0]    valid_row, hit_way, way_we;
  logic [WAY_W-1:0]      victim;
  logic [TAG_W-1:0]      tag_q  [WAY_NUM];
  logic [LINE_W-1:0]     data_q [WAY_NUM];
  logic [LINE_W-1:0]     hit_data;

  assign idx_r = pc_r[OFF_W +: IDX_W];
  assign tag_r = pc_r[ADDR_WIDTH-1 -: TAG_W];

  assign acc = f0_valid_i && !squash_pipe_i && !flush_pending &&
               (state == S_IDLE ||
                (state == S_LOOKUP && hit && !stall_icache_i) ||
                (state == S_RESP && !stall_icache_i));

  // Writes only happen while a miss is outstanding, when no read can be accepted.
  assign refill_wr = refill_valid_i && (state == S_MISS_WAIT || state == S_DRAIN);
  assign sram_addr = acc ? f0_pc_i[OFF_W +: IDX_W] : idx_r;
  assign flush_clr = (state == S_IDLE) && flush_pending;

  icache_replace #(.WAY_NUM(WAY_NUM), .SET_NUM(SET_NUM)) u_replace (
    .clk       (clk),
    .rst       (rst),
    .flush_clr (flush_clr),
    .idx       (idx_r),
    .upd       (refill_wr),
    .valid_row (valid_row),
    .victim    (victim)
  );

  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
    assign way_we[w]  = refill_wr && (victim == WAY_W'(w));
    assign hit_way[w] = valid_row[w] && (tag_q[w] == tag_r);

    sram_model #(.DEPTH(SET_NUM), .WIDTH(TAG_W)) u_tag (
      .clk   (clk),
      .en    (acc || way_we[w]),
      .we    (way_we[w]),
      .addr  (sram_addr),
      .wdata (tag_r),
      .rdata (tag_q[w])
    );

    sram_model #(.DEPTH(SET_NUM), .WIDTH(LINE_W)) u_data (
      .clk   (clk),
      .en    (acc || way_we[w]),
      .we    (way_we[w]),
      .addr  (sram_addr),
      .wdata (refill_data_i),
      .rdata (data_q[w])
    );
  end

  assign hit = |hit_way;

  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (hit_way[w]) hit_data = hit_data | data_q[w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc_r          <= '0;
      line_r        <= '0;
      flush_pending <= 1'b0;
      flush_ack_r   <= 1'b0;
    end else begin
      state       <= state_nxt;
      flush_ack_r <= flush_clr;
      if (acc)       pc_r   <= f0_pc_i;
      if (refill_wr) line_r <= refill_data_i;
      if (flush_clr)    flush_pending <= 1'b0;
      else if (flush_i) flush_pending <= 1'b1;
    end
  end

  // Squash overrides everything; a miss already handed to memory must drain.
  always_comb begin
    state_nxt = state;
    if (squash_pipe_i) begin
      case (state)
        S_MISS_WAIT, S_DRAIN: state_nxt = refill_valid_i ? S_IDLE : S_DRAIN;
        default:              state_nxt = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE:      state_nxt = acc ? S_LOOKUP : S_IDLE;
        S_LOOKUP:    if (!hit)               state_nxt = S_MISS_REQ;
                     else if (!stall_icache_i) state_nxt = acc ? S_LOOKUP : S_IDLE;
        S_MISS_REQ:  if (miss_ready_i)   state_nxt = S_MISS_WAIT;
        S_MISS_WAIT: if (refill_valid_i) state_nxt = S_RESP;
        S_RESP:      if (!stall_icache_i) state_nxt = acc ? S_LOOKUP : S_IDLE;
        S_DRAIN:     if (refill_valid_i) state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_f0_o     = f0_valid_i && !acc;
    icache_valid_o = !squash_pipe_i && ((state == S_LOOKUP && hit) || state == S_RESP);
    icache_pc_o    = icache_valid_o ? pc_r : '0;
    icache_data_o  = '0;
    if (icache_valid_o) icache_data_o = (state == S_RESP) ? line_r : hit_data;
    miss_valid_o   = (state == S_MISS_REQ) && !squash_pipe_i;
    miss_addr_o    = (state == S_MISS_REQ) ? ADDR_WIDTH'(line_align(64'(pc_r), OFF_W)) : '0;
    refill_ready_o = (state == S_MISS_WAIT) || (state == S_DRAIN);
    flush_ack_o    = flush_ack_r;
  end

endmodule

// File: tb/tb_icache_nway.sv
// Randomized self-checking bench for icache_nway against a transaction-level cache model.
module tb_icache_nway;
  import icache_pkg::*;

  localparam int WAYS = 4, SETS = 64, LB = 64, AW = 64, LW = 8 * LB;
  localparam int M_NONE = 0, M_LOOKUP = 1, M_MREQ = 2, M_MWAIT = 3, M_REFILL = 4, M_OUT = 5;

  logic          clk = 1'b0, rst;
  logic          f0_valid, stall_f0, icache_valid, stall_icache;
  logic [AW-1:0] f0_pc, icache_pc, miss_addr;
  logic [LW-1:0] icache_data, refill_data;
  logic          miss_valid, miss_ready, refill_valid, refill_ready;
  logic          squash, flush, flush_ack;

  icache_nway #(.WAY_NUM(WAYS), .SET_NUM(SETS), .LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .f0_valid_i(f0_valid), .f0_pc_i(f0_pc), .stall_f0_o(stall_f0),
    .icache_valid_o(icache_valid), .icache_pc_o(icache_pc), .icache_data_o(icache_data),
    .stall_icache_i(stall_icache), .miss_valid_o(miss_valid), .miss_ready_i(miss_ready),
    .miss_addr_o(miss_addr), .refill_valid_i(refill_valid), .refill_ready_o(refill_ready),
    .refill_data_i(refill_data), .squash_pipe_i(squash), .flush_i(flush), .flush_ack_o(flush_ack)
  );

  always #5 clk = ~clk;

  int            checks = 0, errors = 0;
  bit            cmp_en = 0, check_all = 0, lit_en = 0;
  logic [AW-1:0] lit_pc, lit_addr;
  logic          exp_stall_f0, exp_valid, exp_miss_valid, exp_refill_ready, exp_flush_ack;
  logic [AW-1:0] exp_pc, exp_miss_addr;
  logic [LW-1:0] exp_data;

  logic [63:0]   m_tag   [SETS][WAYS];
  bit            m_valid [SETS][WAYS];
  int            m_rr    [SETS];
  int            sets_pool [3] = '{1, 2, 5};

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [63:0] pc);
    return pc - (pc % LB);
  endfunction

  function automatic int set_of(input logic [63:0] pc);
    return int'((pc / LB) % SETS);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] pc);
    return pc / (LB * SETS);
  endfunction

  // Memory contents: a fixed scramble of the line address, one word per 32 bits.
  function automatic logic [LW-1:0] mem_line(input logic [63:0] la);
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++)
      r[i*32 +: 32] = (la[31:0] * 32'h9E3779B1 + 32'(i) * 32'h7F4A7C15) ^ la[47:16];
    return r;
  endfunction

  function automatic bit model_hit(input logic [63:0] pc);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set_of(pc)][w] && m_tag[set_of(pc)][w] == tag_of(pc)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_install(input logic [63:0] pc);
    int s, v;
    s = set_of(pc);
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = tag_of(pc);
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    f0_valid = 0; stall_icache = 0; squash = 0; miss_ready = 0; refill_valid = 0; flush = 0;
    exp_stall_f0 = 0; exp_valid = 0; exp_miss_valid = 0; exp_refill_ready = 0; exp_flush_ack = 0;
  endtask

  // Fetch attempts in cycles where the cache cannot accept must be stalled.
  task automatic noise();
    f0_valid     = 1'($urandom_range(0, 1));
    f0_pc        = {$urandom, $urandom};
    exp_stall_f0 = f0_valid;
  endtask

  task automatic present(input logic [63:0] pc, input int stall_n, input bit sq);
    for (int k = 0; k <= stall_n; k++) begin
      quiet();
      exp_valid = 1; exp_pc = pc; exp_data = mem_line(line_of(pc));
      if (k < stall_n) begin
        stall_icache = 1; f0_valid = 1; f0_pc = {$urandom, $urandom}; exp_stall_f0 = 1;
      end
      if (sq) begin squash = 1; exp_valid = 0; end
      step();
      if (sq) break;
    end
    quiet();
  endtask

  task automatic fetch(input logic [63:0] pc, input int stall_n, input int mode,
                       input bit flush_w, input int lit_hit);
    logic [63:0] la;
    bit          hit, flushed;
    int          n;
    la = line_of(pc);
    flushed = 0;
    quiet(); f0_valid = 1; f0_pc = pc; step();
    hit = model_hit(pc);
    if (lit_hit >= 0) chk("lit_hit", LW'(hit), LW'(lit_hit[0]));
    if (mode == M_LOOKUP) begin
      quiet(); noise(); squash = 1; step();
    end else if (hit) begin
      present(pc, stall_n, mode == M_OUT);
    end else begin
      quiet(); noise(); step();
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        quiet(); noise(); exp_miss_valid = 1; exp_miss_addr = la; step();
      end
      quiet(); noise(); miss_ready = 1;
      if (mode == M_MREQ) squash = 1;
      else begin exp_miss_valid = 1; exp_miss_addr = la; end
      step();
      if (mode != M_MREQ) begin
        quiet(); noise(); exp_refill_ready = 1;
        if (flush_w) begin flush = 1; flushed = 1; end
        if (mode == M_MWAIT) squash = 1;
        step();
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
          quiet(); noise(); exp_refill_ready = 1; step();
        end
        quiet(); noise(); exp_refill_ready = 1;
        refill_valid = 1; refill_data = mem_line(la);
        if (mode == M_REFILL) squash = 1;
        step();
        model_install(pc);
        if (mode != M_MWAIT && mode != M_REFILL) present(pc, stall_n, mode == M_OUT);
      end
    end
    if (flushed) begin
      quiet(); noise(); step();
      quiet(); exp_flush_ack = 1; step();
      model_clear();
    end
    quiet();
  endtask

  task automatic flush_idle();
    quiet(); flush = 1; step();
    quiet(); noise(); step();
    quiet(); exp_flush_ack = 1; step();
    model_clear();
    quiet();
  endtask

  function automatic logic [63:0] rand_pc();
    return 64'($urandom_range(1, 6)) * (LB * SETS) + 64'(sets_pool[$urandom_range(0, 2)]) * LB
           + 64'($urandom_range(0, LB - 1));
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall_f0", LW'(stall_f0), LW'(exp_stall_f0));
      chk("icache_valid", LW'(icache_valid), LW'(exp_valid));
      chk("miss_valid", LW'(miss_valid), LW'(exp_miss_valid));
      chk("refill_ready", LW'(refill_ready), LW'(exp_refill_ready));
      chk("flush_ack", LW'(flush_ack), LW'(exp_flush_ack));
      if (exp_valid) begin
        chk("icache_pc", LW'(icache_pc), LW'(exp_pc));
        chk("icache_data", icache_data, exp_data);
        if (lit_en) chk("lit_pc", LW'(icache_pc), LW'(lit_pc));
      end
      if (exp_miss_valid) begin
        chk("miss_addr", LW'(miss_addr), LW'(exp_miss_addr));
        if (lit_en) chk("lit_miss_addr", LW'(miss_addr), LW'(lit_addr));
      end
      if (check_all) begin
        chk("reset_pc", LW'(icache_pc), '0);
        chk("reset_data", icache_data, '0);
        chk("reset_miss_addr", LW'(miss_addr), '0);
      end
      if (dut.state == S_LOOKUP) begin
        checks++;
        if (!$onehot0(dut.hit_way)) begin
          errors++;
          $display("[TB] FAIL multi_hit: hit_way %b expected at most one bit", dut.hit_way);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int m, mode;
    bit fw;
    rst = 1; f0_pc = '0; refill_data = '0; exp_pc = '0; exp_miss_addr = '0; exp_data = '0;
    lit_pc = '0; lit_addr = '0;
    quiet();
    model_clear();
    @(posedge clk); #1;
    cmp_en = 1; check_all = 1;
    step(); step();
    rst = 0; check_all = 0;

    // Cold miss, then refetch hits; literal PC and aligned miss address.
    lit_en = 1; lit_pc = 64'h1044; lit_addr = 64'h1040;
    fetch(64'h1044, 0, M_NONE, 0, 0);
    lit_en = 0;
    fetch(64'h1044, 0, M_NONE, 0, 1);

    // Five-plus conflicting tags in set 1 exercise invalid-first then round-robin.
    fetch(64'h2040, 0, M_NONE, 0, 0);
    fetch(64'h3040, 0, M_NONE, 0, 0);
    fetch(64'h4040, 0, M_NONE, 0, 0);
    fetch(64'h5040, 0, M_NONE, 0, 0);
    fetch(64'h6040, 0, M_NONE, 0, 0);
    fetch(64'h1040, 0, M_NONE, 0, 0);
    fetch(64'h4040, 3, M_NONE, 0, 1);
    fetch(64'h2040, 0, M_NONE, 0, 0);

    // Squashes: drained refill is kept, squashed request is not.
    fetch(64'h7080, 0, M_MWAIT, 0, 0);
    fetch(64'h7080, 1, M_NONE, 0, 1);
    fetch(64'h8080, 0, M_MREQ, 0, 0);
    fetch(64'h8080, 0, M_NONE, 0, 0);
    fetch(64'h80C0, 0, M_REFILL, 0, 0);
    fetch(64'h80C0, 0, M_OUT, 0, 1);

    // Flush during a miss invalidates everything, including the new line.
    fetch(64'h90C0, 2, M_NONE, 1, 0);
    fetch(64'h90C0, 0, M_NONE, 0, 0);
    fetch(64'h7080, 0, M_NONE, 0, 0);
    flush_idle();
    fetch(64'h90C0, 0, M_NONE, 0, 0);

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 19) == 0) flush_idle();
      else begin
        m    = $urandom_range(0, 9);
        mode = (m < 5) ? M_NONE : m - 4;
        fw   = (mode == M_NONE) && ($urandom_range(0, 9) == 0);
        fetch(rand_pc(), $urandom_range(0, 2), mode, fw, -1);
      end
    end

    quiet(); step();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
